jtsdram_arb: RTL and testbench

- Round-robin arbiter sharing the single SDRAM command/address bus among the four per-bank test engines (banks 0-3) and the refresh engine.
- Sits between the bank engines and the SDRAM command multiplexer.
- Guarantees one owner at a time, a one-cycle bus turnaround between owners, and periodic refresh insertion with priority over bank traffic.

---
 rtl/jtsdram_arb_if.sv | 48 ++++
 rtl/jtsdram_arb.sv | 196 +++++++++++++++++++
 tb/tb_jtsdram_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtsdram_arb_if.sv
// ---------------------------------------------------------------------------
// jtsdram_arb_if
// Bundles the signals between the SDRAM bus arbiter, the four bank test
// engines and the refresh engine.
//
//   req          4  level request per bank, held for the whole burst
//   grant        4  one-hot grant, at most one bit set
//   grant_idx    2  index of the current or most recent grant
//   bus_busy     1  high while a bank owns the bus or a refresh runs
//   rfsh_start   1  one-cycle pulse launching a refresh
//   rfsh_done    1  pulse from the refresh engine on completion
//   rfsh_late    1  sticky: a refresh period expired with one still pending
//   err_timeout  1  sticky: a bank was forcibly released
//
// Modports: master = arbiter side, slave = requester / refresh-engine side.
// ---------------------------------------------------------------------------
interface jtsdram_arb_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       bus_busy;
    logic       rfsh_start;
    logic       rfsh_done;
    logic       rfsh_late;
    logic       err_timeout;

    modport master (
        input  req,
        input  rfsh_done,
        output grant,
        output grant_idx,
        output bus_busy,
        output rfsh_start,
        output rfsh_late,
        output err_timeout
    );

    modport slave (
        output req,
        output rfsh_done,
        input  grant,
        input  grant_idx,
        input  bus_busy,
        input  rfsh_start,
        input  rfsh_late,
        input  err_timeout
    );
endinterface

// File: rtl/jtsdram_arb.sv
// ---------------------------------------------------------------------------
// jtsdram_arb
// Round-robin arbiter sharing the SDRAM command/address bus between the four
// per-bank test engines and the refresh engine. One owner at a time, one
// turnaround cycle between owners, periodic refresh with priority over banks.
//
// Ports:
//   rst   in  asynchronous, active-high reset
//   clk   in  clock
//   bus   jtsdram_arb_if.master (req, rfsh_done in; grant, grant_idx,
//         bus_busy, rfsh_start, rfsh_late, err_timeout out)
//
// Parameters:
//   RFSH_PERIOD  cycles between refresh requests (16..65535)
//   IDX_W        grant index width (2, four requesters)
//   TIMEOUT      max cycles a bank may hold the bus (timeout build only)
//
// Build option: define JTSDRAM_ARB_TIMEOUT_EN to bound bank hold time and
// drive err_timeout; otherwise grants are unbounded and err_timeout is 0.
// ---------------------------------------------------------------------------
module jtsdram_arb #(
    parameter int unsigned RFSH_PERIOD = 780,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic          rst,
    input  logic          clk,
    jtsdram_arb_if.master bus
);

    localparam int unsigned NREQ = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP,
        RFSH
    } state_t;

    state_t            state, state_nx;
    logic [NREQ-1:0]   grant, grant_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              rfsh_start, start_nx;
    logic              take_rfsh;

    logic [15:0]       rfsh_cnt;
    logic              rfsh_exp;
    logic              rfsh_pend;
    logic              rfsh_late;

    logic [NREQ-1:0]   eligible;
    logic              timeout_hit;
    logic              pick_ok;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;

    assign rfsh_exp = (rfsh_cnt == 16'd0);

    // Round-robin scan starting just after the most recent grant.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = idx;
        cand     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = idx + IDX_W'(i);
            if (!pick_ok && eligible[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        idx_nx    = idx;
        start_nx  = 1'b0;
        take_rfsh = 1'b0;
        case (state)
            IDLE: begin
                if (rfsh_pend) begin
                    state_nx  = RFSH;
                    start_nx  = 1'b1;
                    take_rfsh = 1'b1;
                end else if (pick_ok) begin
                    grant_nx           = '0;
                    grant_nx[pick_idx] = 1'b1;
                    idx_nx             = pick_idx;
                    state_nx           = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[idx] || timeout_hit) begin
                    grant_nx = '0;
                    state_nx = GAP;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            RFSH: begin
                // A done pulse coincident with the start pulse belongs to
                // no refresh of ours; only later samples count.
                if (bus.rfsh_done && !rfsh_start) begin
                    state_nx = GAP;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            idx        <= '1;
            rfsh_start <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            idx        <= idx_nx;
            rfsh_start <= start_nx;
        end
    end

    // Free-running refresh timer; requests are not queued, a second expiry
    // while one is still waiting only flags rfsh_late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfsh_cnt  <= 16'(RFSH_PERIOD - 1);
            rfsh_pend <= 1'b0;
            rfsh_late <= 1'b0;
        end else begin
            rfsh_cnt  <= rfsh_exp ? 16'(RFSH_PERIOD - 1) : rfsh_cnt - 16'd1;
            rfsh_pend <= rfsh_exp | (rfsh_pend & ~take_rfsh);
            if (rfsh_exp && rfsh_pend && !take_rfsh) begin
                rfsh_late <= 1'b1;
            end
        end
    end

`ifdef JTSDRAM_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic [NREQ-1:0]   blocked;
    logic              err_timeout;

    assign timeout_hit = (state == GRANT) && bus.req[idx] &&
                         (hold_cnt == HOLD_W'(TIMEOUT - 1));

    // A forcibly released bank stays out of the scan until its req is seen
    // low, so it cannot immediately recapture the bus.
    assign eligible = bus.req & ~blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            blocked     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (timeout_hit && idx == IDX_W'(i)) begin
                    blocked[i] <= 1'b1;
                end else if (!bus.req[i]) begin
                    blocked[i] <= 1'b0;
                end
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_timeout;
`else
    assign timeout_hit     = 1'b0;
    assign eligible        = bus.req;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.grant      = grant;
    assign bus.grant_idx  = idx;
    assign bus.bus_busy   = (state == GRANT) || (state == RFSH);
    assign bus.rfsh_start = rfsh_start;
    assign bus.rfsh_late  = rfsh_late;

endmodule

// File: tb/tb_jtsdram_arb.sv
// ---------------------------------------------------------------------------
// tb_jtsdram_arb
// Directed bench for jtsdram_arb. Two arbiters share clk/rst: dut with
// RFSH_PERIOD=32 for bank traffic, dut16 with RFSH_PERIOD=16 for refresh
// lateness. Edge numbers in comments count posedges after reset release.
// ---------------------------------------------------------------------------
module tb_jtsdram_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jtsdram_arb_if a_if ();
    jtsdram_arb_if b_if ();

    jtsdram_arb #(.RFSH_PERIOD(32), .IDX_W(2), .TIMEOUT(8)) dut (
        .rst (rst),
        .clk (clk),
        .bus (a_if.master)
    );

    jtsdram_arb #(.RFSH_PERIOD(16), .IDX_W(2), .TIMEOUT(8)) dut16 (
        .rst (rst),
        .clk (clk),
        .bus (b_if.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        a_if.req       = '0;
        a_if.rfsh_done = 1'b0;
        b_if.req       = '0;
        b_if.rfsh_done = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    int          b;
    logic [3:0]  exp_g;
    int          n_start;

    initial begin
        a_if.req       = '0;
        a_if.rfsh_done = 1'b0;
        b_if.req       = '0;
        b_if.rfsh_done = 1'b0;

        // ---------------- reset values
        do_reset();
        check("rst_grant", a_if.grant, 4'b0000);
        check("rst_idx", a_if.grant_idx, 2'd3);
        check("rst_busy", a_if.bus_busy, 1'b0);
        check("rst_start", a_if.rfsh_start, 1'b0);
        check("rst_late", a_if.rfsh_late, 1'b0);
        check("rst_err", a_if.err_timeout, 1'b0);

        // ---------------- all four banks requesting: order 0,1,2,3,0
        a_if.req = 4'b1111;
        step(1);
        for (int g = 0; g < 5; g++) begin
            b     = g % 4;
            exp_g = 4'b0001 << b;
            check("rr_grant_c1", a_if.grant, exp_g);
            check("rr_idx", a_if.grant_idx, b);
            check("rr_busy", a_if.bus_busy, 1'b1);
            step(1);
            check("rr_grant_c2", a_if.grant, exp_g);
            step(1);
            check("rr_grant_c3", a_if.grant, exp_g);
            a_if.req[b] = 1'b0;
            step(1);
            check("rr_gap_grant", a_if.grant, 4'b0000);
            check("rr_gap_busy", a_if.bus_busy, 1'b0);
            if (g < 4) a_if.req[b] = 1'b1;
            else       a_if.req    = '0;
            step(1);
            check("rr_idle_grant", a_if.grant, 4'b0000);
            step(1);
        end

        // ---------------- single requester, drop and re-raise
        do_reset();
        a_if.req = 4'b0100;
        check("one_pre", a_if.grant, 4'b0000);
        step(1);
        check("one_grant", a_if.grant, 4'b0100);
        check("one_idx", a_if.grant_idx, 2'd2);
        step(2);
        a_if.req = 4'b0000;
        step(1);
        check("one_drop", a_if.grant, 4'b0000);
        a_if.req = 4'b0100;
        step(1);
        check("one_wait", a_if.grant, 4'b0000);
        step(1);
        check("one_regrant", a_if.grant, 4'b0100);
        a_if.req = 4'b0000;

`ifndef JTSDRAM_ARB_TIMEOUT_EN
        // ---------------- refresh expiry during a long grant (period 32)
        do_reset();
        a_if.req = 4'b0110;
        step(1);                                // e1
        for (int c = 1; c <= 50; c++) begin
            check("hold_grant", a_if.grant, 4'b0010);
            check("hold_no_start", a_if.rfsh_start, 1'b0);
            a_if.rfsh_done = (c == 10);         // stray done outside RFSH
            if (c < 50) step(1);
        end
        a_if.req = 4'b0100;
        step(1);                                // e51: GAP
        check("rf_gap_grant", a_if.grant, 4'b0000);
        check("rf_gap_start", a_if.rfsh_start, 1'b0);
        step(1);                                // e52: IDLE
        check("rf_idle_grant", a_if.grant, 4'b0000);
        check("rf_idle_start", a_if.rfsh_start, 1'b0);
        step(1);                                // e53: RFSH
        check("rf_start", a_if.rfsh_start, 1'b1);
        check("rf_busy", a_if.bus_busy, 1'b1);
        check("rf_no_grant", a_if.grant, 4'b0000);
        check("rf_late0", a_if.rfsh_late, 1'b0);
        a_if.rfsh_done = 1'b1;                  // coincides with start: ignored
        step(1);                                // e54
        a_if.rfsh_done = 1'b0;
        check("rf_done_ign", a_if.bus_busy, 1'b1);
        check("rf_start_pulse", a_if.rfsh_start, 1'b0);
        a_if.rfsh_done = 1'b1;
        step(1);                                // e55: GAP
        a_if.rfsh_done = 1'b0;
        check("rf_done_busy", a_if.bus_busy, 1'b0);
        step(1);                                // e56: IDLE
        check("rf_after_idle", a_if.grant, 4'b0000);
        step(1);                                // e57
        check("rf_bank2", a_if.grant, 4'b0100);
        check("no_timeout_err", a_if.err_timeout, 1'b0);
        a_if.req = 4'b0000;
`endif

        // ---------------- refresh lateness on dut16 (period 16)
        do_reset();
        n_start = 0;
        for (int e = 1; e <= 63; e++) begin
            step(1);
            if (e >= 18 && b_if.rfsh_start) n_start++;
            if (e == 16) check("late_e16_start", b_if.rfsh_start, 1'b0);
            if (e == 17) begin
                check("late_e17_start", b_if.rfsh_start, 1'b1);
                check("late_e17_busy", b_if.bus_busy, 1'b1);
            end
            if (e == 32) check("late_e32", b_if.rfsh_late, 1'b0);
            if (e == 47) check("late_e47", b_if.rfsh_late, 1'b0);
            if (e == 48) check("late_e48", b_if.rfsh_late, 1'b1);
            if (e == 56) b_if.rfsh_done = 1'b1;
            if (e == 57) begin
                b_if.rfsh_done = 1'b0;
                check("late_gap_busy", b_if.bus_busy, 1'b0);
            end
            if (e == 58) check("late_idle_start", b_if.rfsh_start, 1'b0);
            if (e == 59) check("late_restart", b_if.rfsh_start, 1'b1);
            if (e == 63) check("late_sticky", b_if.rfsh_late, 1'b1);
        end
        check("late_start_count", n_start, 1);

        // ---------------- asynchronous reset mid-grant / mid-refresh
        do_reset();
        step(15);
        a_if.req = 4'b1000;
        step(1);                                // e16
        check("ar_grant3", a_if.grant, 4'b1000);
        step(1);                                // e17
        check("ar_grant3_hold", a_if.grant, 4'b1000);
        check("ar_b_start", b_if.rfsh_start, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_grant0", a_if.grant, 4'b0000);
        check("ar_idx3", a_if.grant_idx, 2'd3);
        check("ar_a_start", a_if.rfsh_start, 1'b0);
        check("ar_b_start0", b_if.rfsh_start, 1'b0);
        check("ar_b_busy0", b_if.bus_busy, 1'b0);
        a_if.req = 4'b1001;
        step(2);
        rst = 1'b0;
        step(1);
        check("ar_first_bank0", a_if.grant, 4'b0001);
        check("ar_first_idx", a_if.grant_idx, 2'd0);
        a_if.req = 4'b0000;

`ifdef JTSDRAM_ARB_TIMEOUT_EN
        // ---------------- forced release after TIMEOUT=8 cycles
        do_reset();
        a_if.req = 4'b0011;
        step(1);                                // e1
        check("to_grant0", a_if.grant, 4'b0001);
        for (int k = 2; k <= 8; k++) begin
            step(1);
            check("to_hold", a_if.grant, 4'b0001);
        end
        check("to_err0", a_if.err_timeout, 1'b0);
        step(1);                                // e9
        check("to_drop", a_if.grant, 4'b0000);
        check("to_err", a_if.err_timeout, 1'b1);
        step(1);                                // e10
        check("to_idle", a_if.grant, 4'b0000);
        step(1);                                // e11
        check("to_bank1", a_if.grant, 4'b0010);
        a_if.req = 4'b0001;
        for (int k = 12; k <= 15; k++) begin
            step(1);
            check("to_blocked", a_if.grant, 4'b0000);
        end
        a_if.req = 4'b0000;
        step(1);                                // e16
        a_if.req = 4'b0001;
        step(1);                                // e17
        check("to_regrant", a_if.grant, 4'b0001);
        check("to_err_sticky", a_if.err_timeout, 1'b1);
        a_if.req = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
